// File: rtl/io_mode_counter.sv
// Multi-channel register core: each channel can hold, shift in serial data, or
// count up/down behind a shared prescaler. Only the selected channel updates.
module io_mode_counter #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 1,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] MODE_SHIFT = 2'b01;

  logic [WIDTH-1:0] ch_vec [CHANNELS];
  logic [WIDTH-1:0] q_mux;
  logic [PW-1:0]    presc_reg;
  logic [1:0]       mode_q_reg;
  logic             wrap_reg;
  logic             sel_ok;
  logic             mode_same;
  logic             tick;
  logic             step;
  logic             step_up;

  assign sel_ok    = (int'(sel) < CHANNELS);
  assign mode_same = (mode == mode_q_reg);
  assign tick      = (presc_reg == PW'(PRESCALE - 1));
  // A mode change suppresses the step so every count run starts from a fresh prescale.
  assign step      = en && mode_same && mode[1] && tick;
  assign step_up   = ~mode[0];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] ch_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ch_reg <= '0;
        end else if (en && sel == SELW'(gi)) begin
          if (mode == MODE_SHIFT) begin
            ch_reg <= {ch_reg[WIDTH-2:0], din};
          end else if (step) begin
            ch_reg <= step_up ? ch_reg + WIDTH'(1) : ch_reg - WIDTH'(1);
          end
        end
      end

      assign ch_vec[gi] = ch_reg;
    end
  endgenerate

  always_comb begin
    q_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SELW'(i)) q_mux = ch_vec[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg  <= '0;
      mode_q_reg <= 2'b00;
      wrap_reg   <= 1'b0;
    end else begin
      mode_q_reg <= mode;
      // q_mux is the pre-step value of the channel being stepped.
      wrap_reg   <= step && sel_ok && (step_up ? &q_mux : ~|q_mux);
      if (en) begin
        if (!mode_same) begin
          presc_reg <= '0;
        end else if (mode[1]) begin
          presc_reg <= tick ? '0 : presc_reg + PW'(1);
        end
      end
    end
  end

  assign q    = q_mux;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_io_mode_counter.sv
// Randomized scoreboard bench for io_mode_counter (3 channels, prescale 3):
// stimulus updates a reference model and queues expectations, a monitor compares.
module tb_io_mode_counter;

  localparam int W   = 7;
  localparam int NCH = 3;
  localparam int PS  = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         din = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [1:0]   sel = 2'b00;
  logic [W-1:0] q;
  logic         wrap;

  io_mode_counter #(.WIDTH(W), .CHANNELS(NCH), .PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .din(din), .sel(sel), .q(q), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  logic [W:0] exp_q [$];

  // Reference model: channel values, enabled count cycles since last step, last mode.
  int m_ch [NCH];
  int m_cnt;
  int m_last_mode;
  int m_wrap;

  function automatic int m_q(int s);
    return (s < NCH) ? m_ch[s] : 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) m_ch[i] = 0;
    m_cnt = 0;
    m_last_mode = 0;
    m_wrap = 0;
  endtask

  task automatic cycle(bit e, bit [1:0] m, bit d, bit [1:0] s);
    int nw;
    nw = 0;
    @(negedge clk);
    rst_n = 1'b1;
    en = e; mode = m; din = d; sel = s;
    #1;
    check("q_comb", q, m_q(s));
    check("wrap_hold", wrap, m_wrap);
    if (e) begin
      if (m == 1 && s < NCH) m_ch[s] = (m_ch[s] * 2 + d) % MOD;
      if (m != m_last_mode) begin
        m_cnt = 0;
      end else if (m >= 2) begin
        m_cnt++;
        if (m_cnt == PS) begin
          m_cnt = 0;
          if (s < NCH) begin
            if (m == 2) begin
              nw = (m_ch[s] == MOD - 1);
              m_ch[s] = (m_ch[s] + 1) % MOD;
            end else begin
              nw = (m_ch[s] == 0);
              m_ch[s] = (m_ch[s] + MOD - 1) % MOD;
            end
          end
        end
      end
    end
    m_wrap = nw;
    m_last_mode = m;
    exp_q.push_back({W'(m_q(s)), nw[0]});
  endtask

  // Asynchronous reset asserted between edges; takes effect without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_wrap", wrap, 0);
    model_clear();
    exp_q.push_back('0);
  endtask

  initial begin : monitor
    logic [W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        check("q", q, e[W:1]);
        check("wrap", wrap, e[0]);
        $display("txn %0d: sel=%0d mode=%0d en=%0b q=%02h wrap=%0b", n_txn, sel, mode, en, q, wrap);
      end
    end
  end

  initial begin : stimulus
    logic [6:0] pat;
    bit         e;
    bit [1:0]   m;
    bit [1:0]   s;
    model_clear();
    #3;
    check("reset_q", q, 0);
    check("reset_wrap", wrap, 0);

    pat = 7'b1011001;
    for (int i = 6; i >= 0; i--) cycle(1'b1, 2'b01, pat[i], 2'd0);
    cycle(1'b1, 2'b00, 1'b0, 2'd1);

    pat = 7'h7E;
    for (int i = 6; i >= 0; i--) cycle(1'b1, 2'b01, pat[i], 2'd0);
    repeat (1 + 3 * PS) cycle(1'b1, 2'b10, 1'b0, 2'd0);

    repeat (1 + 2 * PS) cycle(1'b1, 2'b11, 1'b0, 2'd2);
    cycle(1'b1, 2'b11, 1'b0, 2'd2);
    repeat (5) cycle(1'b0, 2'b11, 1'b0, 2'd2);
    repeat (3) cycle(1'b1, 2'b11, 1'b0, 2'd2);

    repeat (2 * PS) cycle(1'b1, 2'b10, 1'b0, 2'd1);
    repeat (4) cycle(1'b1, 2'b10, 1'b1, 2'd3);
    repeat (3) cycle(1'b1, 2'b01, 1'b1, 2'd3);
    cycle(1'b1, 2'b00, 1'b0, 2'd0);
    do_reset();

    e = 1'b1; m = 2'b10; s = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) s = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle(e, m, 1'($urandom_range(0, 1)), s);
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_mode_counter.md
Name: io_mode_counter

Overview:
- Parametrised multi-channel sequential core instantiated inside the 8-in/8-out project top wrapper.
- Wrapper pin map:
  - io_in[0] = clk, io_in[1] = rst_n, io_in[2] = en, io_in[4:3] = mode, io_in[5] = din, io_in[6] = sel.
  - io_out[6:0] = q, io_out[7] = wrap.
- Each of CHANNELS registers can be held, serially loaded, or counted up/down, with a prescaler on counting.
- Successor to the fixed 8-bit pass-through template: adds width/channel/prescale parameters and mode-selected behaviour.

Parameters:
WIDTH, 7, bits per channel register and width of q (>=2)
CHANNELS, 2, number of channel registers (>=1); SELW = max(1, clog2(CHANNELS))
PRESCALE, 1, count-mode clock divider; count step every PRESCALE enabled cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
en  input  1  global enable; when 0 no channel or prescaler state changes
mode  input  2  00 HOLD, 01 SHIFT, 10 UP, 11 DOWN
din  input  1  serial data bit for SHIFT mode
sel  input  SELW  selected channel index
q  output  WIDTH  contents of selected channel register
wrap  output  1  registered one-cycle pulse on count wrap of selected channel

Behaviour:
- Reset (rst_n=0, async assert, sync release on next edge):
  - all channel regs = 0, prescaler = 0, mode_q = 00, wrap = 0.
  - q therefore reads 0.
- q is combinational: q = ch[sel]. A sel change is visible the same cycle.
- sel >= CHANNELS: q = 0, no channel updates, wrap = 0.
- Only ch[sel] may change in a cycle; all other channels hold.
- mode_q registers mode every cycle, regardless of en.
- Mode change: if mode != mode_q, the prescaler clears to 0 this cycle and no count step occurs. SHIFT still applies; HOLD does nothing anyway.
- Prescaler:
  - Counts 0..PRESCALE-1 only when en=1 and mode is UP/DOWN (and unchanged).
  - tick = (prescaler == PRESCALE-1); prescaler wraps to 0 on tick.
  - PRESCALE=1: tick every enabled cycle.
  - Prescaler holds when en=0 or mode is HOLD/SHIFT.
- HOLD (00): no change.
- SHIFT (01), en=1: ch[sel] <= {ch[sel][WIDTH-2:0], din} every cycle; prescaler not used.
- UP (10), en=1, tick: ch[sel] <= ch[sel]+1 mod 2^WIDTH.
- DOWN (11), en=1, tick: ch[sel] <= ch[sel]-1 mod 2^WIDTH.
- wrap:
  - Set to 1 for exactly the cycle after a step where UP took all-ones -> 0, or DOWN took 0 -> all-ones. Otherwise 0.
  - Tied to the channel that wrapped, even if sel changes in the following cycle.
- sel change mid-count: prescaler is not cleared; the new channel resumes from its held value at the next tick.
- Reset mid-operation: all state clears immediately; first step after release needs a full PRESCALE ticks.
- No combinational path from din, mode or en to q within the same cycle. The only combinational path to q is from sel.

Test Plan:
1. Reset then SHIFT: rst_n=0 -> q=0, wrap=0. Release, sel=0, en=1, mode=01, din=1,0,1,1,0,0,1 over 7 cycles -> q=7'b1011001. sel=1 -> q=0.
2. UP wrap, PRESCALE=1: load ch0=7'h7E via SHIFT, then mode=10 (first cycle clears prescaler, no step).
   - Following cycles: q=7F, then 00.
   - wrap=1 exactly on the cycle q shows 00, 0 otherwise.
3. DOWN with PRESCALE=4 from 0: 4 enabled cycles after the mode-change cycle -> q=7F, wrap pulse. 4 more -> 7E.
4. en gating: mid-prescale (prescaler=2) drop en for 5 cycles -> q and prescaler frozen. Raise en -> step occurs after 1 more cycle.
5. Channel isolation: ch0=05, ch1=40. sel=1, UP for 3 ticks -> ch1=43, ch0 still 05 (check via sel=0). sel=1 (CHANNELS=3 build), sel=3 -> q=0, no updates.
6. Async reset mid-count: assert rst_n between clock edges while q=33 -> q=0 without a clock edge. wrap=0.
